// File: rtl/eq_coeff_bank.sv
// eq_coeff_bank: double-buffered equalizer coefficient store with atomic commit
//   clk, rst          : clock, synchronous active-high reset
//   eq_coeff_addr/eq_coeff : combinational read of the active bank (0 when out of range)
//   eq_idle           : equalizer between samples; the bank swap waits for it
//   wr_tdata/wr_taddr/wr_tvalid/wr_tready : host writes into the shadow bank
//   commit            : publish shadow bank; commit_pending shows the swap is waiting
//   active_bank       : bank currently driving eq_coeff
//   wr_err            : one-cycle pulse after an out-of-range write is consumed
module eq_coeff_bank #(
   parameter int NR_CHANNELS    = 4,
   parameter int NR_EQ_BANDS    = 8,
   parameter int EQ_COEFF_WIDTH = 32,
   localparam int N  = NR_CHANNELS * NR_EQ_BANDS * 5,
   localparam int AW = (N > 1) ? $clog2(N) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [AW-1:0]             eq_coeff_addr,
   output logic [EQ_COEFF_WIDTH-1:0] eq_coeff,
   input  logic                      eq_idle,
   input  logic [EQ_COEFF_WIDTH-1:0] wr_tdata,
   input  logic [AW-1:0]             wr_taddr,
   input  logic                      wr_tvalid,
   output logic                      wr_tready,
   input  logic                      commit,
   output logic                      commit_pending,
   output logic                      active_bank,
   output logic                      wr_err
);
   localparam logic [1:0] INIT    = 2'd0;
   localparam logic [1:0] IDLE    = 2'd1;
   localparam logic [1:0] PENDING = 2'd2;
   localparam logic [1:0] COPY    = 2'd3;
   localparam logic [EQ_COEFF_WIDTH-1:0] UNITY = EQ_COEFF_WIDTH'(1) << (EQ_COEFF_WIDTH - 4);
   localparam logic [AW:0]   NW   = (AW + 1)'(N);
   localparam logic [AW-1:0] LAST = AW'(N - 1);

   logic [EQ_COEFF_WIDTH-1:0] mem0_q [N];
   logic [EQ_COEFF_WIDTH-1:0] mem1_q [N];
   logic [1:0]    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [2:0]    ph_q, ph_d;
   logic          act_q, act_d;
   logic          err_q, err_d;
   logic          we0, we1;
   logic [AW-1:0] wa;
   logic [EQ_COEFF_WIDTH-1:0] wd;
   logic          wr_in_range, rd_in_range, last;

   assign wr_in_range    = {1'b0, wr_taddr} < NW;
   assign rd_in_range    = {1'b0, eq_coeff_addr} < NW;
   assign last           = cnt_q == LAST;
   assign eq_coeff       = !rd_in_range ? '0 : act_q ? mem1_q[eq_coeff_addr] : mem0_q[eq_coeff_addr];
   assign wr_tready      = state_q == IDLE;
   assign commit_pending = state_q == PENDING;
   assign active_bank    = act_q;
   assign wr_err         = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ph_d    = ph_q;
      act_d   = act_q;
      err_d   = 1'b0;
      we0     = 1'b0;
      we1     = 1'b0;
      wa      = cnt_q;
      wd      = '0;
      case (state_q)
         INIT: begin
            // ph_q tracks the position within b0,b1,b2,a1,a2 so only b0 gets unity
            we0     = 1'b1;
            we1     = 1'b1;
            wd      = (ph_q == 3'd0) ? UNITY : '0;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            ph_d    = (ph_q == 3'd4) ? 3'd0 : ph_q + 3'd1;
            state_d = last ? IDLE : INIT;
         end
         IDLE: begin
            wa      = wr_taddr;
            wd      = wr_tdata;
            we0     = wr_tvalid && wr_in_range && act_q;
            we1     = wr_tvalid && wr_in_range && !act_q;
            err_d   = wr_tvalid && !wr_in_range;
            state_d = commit ? PENDING : IDLE;
         end
         PENDING: begin
            act_d   = eq_idle ? ~act_q : act_q;
            cnt_d   = '0;
            state_d = eq_idle ? COPY : PENDING;
         end
         default: begin
            // act_q already names the new active bank; refresh the new shadow from it
            wd      = act_q ? mem1_q[cnt_q] : mem0_q[cnt_q];
            we0     = act_q;
            we1     = !act_q;
            cnt_d   = last ? '0 : cnt_q + 1'b1;
            state_d = last ? IDLE : COPY;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= INIT;
         cnt_q   <= '0;
         ph_q    <= 3'd0;
         act_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ph_q    <= ph_d;
         act_q   <= act_d;
         err_q   <= err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && we0) mem0_q[wa] <= wd;
      if (!rst && we1) mem1_q[wa] <= wd;
   end
endmodule

// File: doc/eq_coeff_bank.md
EQ_COEFF_BANK -- requirements
Module: eq_coeff_bank

Purpose: double-buffered coefficient store that feeds the equalizer's eq_coeff/eq_coeff_addr port. The equalizer always reads a stable active bank. Host writes go to a shadow bank and are committed atomically between samples.

Interface
REQ-001 Parameter NR_CHANNELS, default 4, audio channel count.
REQ-002 Parameter NR_EQ_BANDS, default 8, biquad bands per channel.
REQ-003 Parameter EQ_COEFF_WIDTH, default 32, coefficient width in bits, signed, gain range -8.0 to <8.0 (1.0 = 2^(EQ_COEFF_WIDTH-4)).
REQ-004 Derived: N = NR_CHANNELS*NR_EQ_BANDS*5 and AW = clog2(N) (minimum 1). Defaults give N=160 and AW=8.
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  in  1  system clock, all logic on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 eq_coeff_addr  in  AW  equalizer read address.
REQ-009 eq_coeff  out  EQ_COEFF_WIDTH  active-bank word at eq_coeff_addr.
REQ-010 eq_idle  in  1  high when the equalizer is between samples (its s_tready).
REQ-011 wr_tdata  in  EQ_COEFF_WIDTH  coefficient write data.
REQ-012 wr_taddr  in  AW  coefficient write address.
REQ-013 wr_tvalid  in  1  write request.
REQ-014 wr_tready  out  1  write accepted when wr_tvalid && wr_tready.
REQ-015 commit  in  1  single-cycle request to publish the shadow bank.
REQ-016 commit_pending  out  1  commit accepted, swap not yet done.
REQ-017 active_bank  out  1  index of the bank driving eq_coeff.
REQ-018 wr_err  out  1  one-cycle pulse on an out-of-range write address.

Function
REQ-019 Storage is two banks of N words each, with word order per channel/band b0,b1,b2,a1,a2, matching the equalizer address order.
REQ-020 eq_coeff SHALL be a combinational read of bank[active_bank][eq_coeff_addr], with zero latency. For eq_coeff_addr >= N it SHALL output 0.
REQ-021 The FSM has four states: INIT, IDLE, PENDING, COPY.
REQ-022 INIT: the address counter sweeps 0..N-1, one word per cycle. Both banks are written with unity passthrough (b0 = 2^(EQ_COEFF_WIDTH-4), others 0). INIT lasts exactly N cycles, then goes to IDLE.
REQ-023 IDLE: wr_tready=1. A handshake writes wr_tdata into the shadow bank at wr_taddr.
REQ-024 In IDLE, a write with wr_taddr >= N SHALL be handshaken (consumed), SHALL NOT modify any bank, and SHALL pulse wr_err for one cycle.
REQ-025 In IDLE, commit=1 moves the FSM to PENDING next cycle. A write handshaken in the same cycle is written first and is included in the commit.
REQ-026 PENDING: wr_tready=0 and commit_pending=1. On the first edge with eq_idle=1, active_bank toggles and the FSM goes to COPY. eq_idle=0 holds PENDING indefinitely.
REQ-027 COPY: wr_tready=0. Exactly N cycles; each cycle copies new-active[k] into the new shadow[k] for k=0..N-1, then returns to IDLE. Afterwards the shadow equals the active bank, so later writes are incremental.
REQ-028 commit while in INIT, PENDING or COPY SHALL be ignored.
REQ-029 Minimum commit-to-IDLE time: commit at cycle 0 (IDLE), PENDING in cycle 1, swap at end of cycle 1 if eq_idle, COPY in cycles 2..N+1, IDLE in cycle N+2.
REQ-030 eq_coeff SHALL change only on the swap edge or during INIT. It never changes during COPY or on writes.

Reset
REQ-031 While rst=1: FSM in INIT with counter 0, wr_tready=0, commit_pending=0, active_bank=0, wr_err=0.
REQ-032 The INIT sweep starts on the first cycle with rst=0. wr_tready rises N cycles after reset release.
REQ-033 rst asserted in any state, including mid-COPY or PENDING, aborts the operation. A pending commit is lost and both banks are re-initialised to unity.

Verification
REQ-034 Reset release: wr_tready=0 for 160 cycles, then 1. eq_coeff at addr 0 = 0x10000000, addr 1 = 0, addr 5 = 0x10000000, addr 200 = 0.
REQ-035 Write addr 3 = 0x01234567, then commit with eq_idle=1: eq_coeff@3 = 0 until the swap edge, then 0x01234567 and active_bank=1. After COPY, write addr 4 = 0x7 and commit: addr 3 stays 0x01234567 and addr 4 reads 0x7.
REQ-036 Commit with eq_idle=0 held for 50 cycles: commit_pending=1, wr_tready=0, active_bank unchanged. Raising eq_idle gives a swap on the next edge and commit_pending=0.
REQ-037 Write to addr 160 in IDLE: handshake completes, wr_err=1 for exactly one cycle, all 160 words unchanged in both banks.
REQ-038 Write addr 10 = 0xABCD with commit in the same cycle: after the swap, eq_coeff@10 = 0xABCD. A second commit during COPY is ignored, with no extra swap.
REQ-039 rst pulse in cycle 40 of COPY: active_bank=0, then after 160 cycles all words are unity and wr_tready=1.
